// File: rtl/gen_imm_pipe_pkg.sv
// Shared definitions for the pipelined RV immediate generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gen_imm_pipe_pkg;

  // Base-ISA major opcodes (instr[6:0])
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;

  // Instruction format tag carried with each decoded entry
  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  // One buffered entry at the widest legal configuration (XLEN=64, 64-bit tag).
  // The top narrows imm/tag to its own XLEN/TAG_W when it stores entries.
  localparam int IMM_W_MAX = 64;
  localparam int TAG_W_MAX = 64;

  typedef struct packed {
    logic [IMM_W_MAX-1:0] imm;
    fmt_e                 fmt;
    logic [TAG_W_MAX-1:0] tag;
  } entry_t;

endpackage

// File: rtl/gen_imm_dec.sv
// Pure combinational RV immediate decoder: instr -> {sign-extended imm, fmt}.
// Latency: 0 cycles. Backpressure: none (stateless).
// Optional: GEN_IMM_SHAMT_EN makes OP_IMM shifts yield a zero-extended shamt.
module gen_imm_dec
  import gen_imm_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o
);

  // Every base-format immediate fits in 32 bits; build it already
  // sign-extended to 32, then widen to XLEN with one signed cast.
  logic [31:0] imm32;

  // Select format and assemble the 32-bit immediate from the opcode.
  always_comb begin
    imm32 = '0;
    fmt_o = FMT_ILL;
    case (instr_i[6:0])
      OP_IMM, LOAD, JALR: begin
        fmt_o = FMT_I;
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
`ifdef GEN_IMM_SHAMT_EN
        // funct3 001 (SLLI) or 101 (SRLI/SRAI): shamt only, funct7/funct6 dropped.
        // Upper bits are zero, so the later signed widening leaves it zero-extended.
        if (instr_i[6:0] == OP_IMM && instr_i[13:12] == 2'b01) begin
          imm32 = {26'b0, (XLEN == 64) ? instr_i[25] : 1'b0, instr_i[24:20]};
        end
`endif
      end
      STORE: begin
        fmt_o = FMT_S;
        imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      BRANCH: begin
        fmt_o = FMT_B;
        imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      end
      LUI, AUIPC: begin
        fmt_o = FMT_U;
        imm32 = {instr_i[31:12], 12'b0};
      end
      JAL: begin
        fmt_o = FMT_J;
        imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      end
      OP: begin
        fmt_o = FMT_R;
        imm32 = '0;
      end
      default: begin
        fmt_o = FMT_ILL;
        imm32 = '0;
      end
    endcase
  end

  // For XLEN=64 this replicates bit 31 (covers U-type sign extension too).
  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/gen_imm_pipe.sv
// Pipelined RV immediate generator: decode at push into a 2-entry output FIFO, count illegals.
// Latency: 1 cycle accept->out_valid when empty. Backpressure: registered in_ready drops at 2 entries.
// Optional: GEN_IMM_SHAMT_EN (shift-immediate shamt decode inside gen_imm_dec).
module gen_imm_pipe
  import gen_imm_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] cnt_ilegal
);

  logic [XLEN-1:0]  dec_imm;
  fmt_e             dec_fmt;
  entry_t           wr_ent;
  entry_t           head;
  logic [XLEN-1:0]  mem_imm_q [2];
  fmt_e             mem_fmt_q [2];
  logic [TAG_W-1:0] mem_tag_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  gen_imm_dec #(.XLEN(XLEN)) u_dec (
    .instr_i (in_instr),
    .imm_o   (dec_imm),
    .fmt_o   (dec_fmt)
  );

  // in_ready_q always equals (count_q < 2), so a push never overfills.
  assign push = in_valid && in_ready_q;
  assign pop  = (count_q != 2'd0) && out_ready;

  // Pack the decoded instruction into the shared entry layout, widened to the max widths.
  always_comb begin
    wr_ent     = '0;
    wr_ent.imm = IMM_W_MAX'(dec_imm);
    wr_ent.fmt = dec_fmt;
    wr_ent.tag = TAG_W_MAX'(in_tag);
  end

  // Next occupancy and saturating illegal-instruction count.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    cnt_d = cnt_q;
    if (push && (dec_fmt == FMT_ILL) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // FIFO storage, pointers, registered in_ready and counter; reset empties everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_imm_q[0] <= '0;
      mem_imm_q[1] <= '0;
      mem_fmt_q[0] <= FMT_R;
      mem_fmt_q[1] <= FMT_R;
      mem_tag_q[0] <= '0;
      mem_tag_q[1] <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      in_ready_q   <= 1'b1;
      cnt_q        <= '0;
    end else begin
      if (push) begin
        mem_imm_q[wr_ptr_q] <= wr_ent.imm[XLEN-1:0];
        mem_fmt_q[wr_ptr_q] <= wr_ent.fmt;
        mem_tag_q[wr_ptr_q] <= wr_ent.tag[TAG_W-1:0];
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q    <= count_d;
      in_ready_q <= (count_d != 2'd2);
      cnt_q      <= cnt_d;
    end
  end

  // Head entry straight from storage: stable while stalled since only pop moves rd_ptr_q.
  always_comb begin
    head     = '0;
    head.imm = IMM_W_MAX'(mem_imm_q[rd_ptr_q]);
    head.fmt = mem_fmt_q[rd_ptr_q];
    head.tag = TAG_W_MAX'(mem_tag_q[rd_ptr_q]);
  end

  assign out_valid  = (count_q != 2'd0);
  assign in_ready   = in_ready_q;
  assign out_imm    = head.imm[XLEN-1:0];
  assign out_fmt    = head.fmt;
  assign out_tag    = head.tag[TAG_W-1:0];
  assign cnt_ilegal = cnt_q;

endmodule

// File: tb/tb_gen_imm_pipe.sv
// Scoreboard bench for gen_imm_pipe: directed cases, backpressure, saturation, reset, random traffic.
module tb_gen_imm_pipe;
  localparam int XLEN  = 32;
  localparam int TAG_W = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] cnt_ilegal;

  gen_imm_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_fmt    (out_fmt),
    .out_tag    (out_tag),
    .cnt_ilegal (cnt_ilegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             sb[$];
  int               checks   = 0;
  int               failures = 0;
  int               pops     = 0;
  logic [CNT_W-1:0] exp_cnt  = '0;
  logic [TAG_W-1:0] tag_ctr  = 32'h1000;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference decode: immediate value assembled as a signed integer from field weights.
  function automatic void model(input logic [31:0] ins, output logic [XLEN-1:0] imm,
                                output logic [2:0] fmt);
    longint v;
    v   = 0;
    fmt = 3'd7;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: begin
        fmt = 3'd1;
        v   = longint'(ins[31:20]) - longint'(ins[31]) * 4096;
`ifdef GEN_IMM_SHAMT_EN
        if (ins[6:0] == 7'h13 && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5))
          v = (XLEN == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
`endif
      end
      7'h23: begin
        fmt = 3'd2;
        v   = longint'({ins[31:25], ins[11:7]}) - longint'(ins[31]) * 4096;
      end
      7'h63: begin
        fmt = 3'd3;
        v   = -longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
              + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      end
      7'h37, 7'h17: begin
        fmt = 3'd4;
        v   = longint'(ins[31:12]) * 4096 - (longint'(ins[31]) <<< 32);
      end
      7'h6f: begin
        fmt = 3'd5;
        v   = -longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
              + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      end
      7'h33: begin
        fmt = 3'd0;
        v   = 0;
      end
      default: begin
        fmt = 3'd7;
        v   = 0;
      end
    endcase
    imm = v[XLEN-1:0];
  endfunction

  // One cycle of stimulus; an accepted instruction pushes its expected entry.
  task automatic drive_cycle(input logic v, input logic [31:0] ins, input logic ordy,
                             input logic lit, input logic [XLEN-1:0] limm, input logic [2:0] lfmt);
    exp_t e;
    @(posedge clk); #1;
    in_valid  = v;
    in_instr  = ins;
    in_tag    = tag_ctr;
    out_ready = ordy;
    @(negedge clk);
    check("cnt_ilegal", 64'(cnt_ilegal), 64'(exp_cnt));
    if (v && in_ready && !rst) begin
      model(ins, e.imm, e.fmt);
      if (lit) begin
        e.imm = limm;
        e.fmt = lfmt;
      end
      e.tag = tag_ctr;
      sb.push_back(e);
      tag_ctr++;
      if (e.fmt == 3'd7 && exp_cnt != {CNT_W{1'b1}}) exp_cnt++;
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic ordy);
    drive_cycle(1'b1, ins, ordy, 1'b0, '0, 3'd0);
  endtask

  task automatic send_lit(input logic [31:0] ins, input logic [XLEN-1:0] imm, input logic [2:0] fmt);
    drive_cycle(1'b1, ins, 1'b1, 1'b1, imm, fmt);
  endtask

  task automatic idle(input logic ordy);
    drive_cycle(1'b0, 32'h0, ordy, 1'b0, '0, 3'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    sb.delete();
    @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_cnt", 64'(cnt_ilegal), 64'd0);
    check("rst_imm", 64'(out_imm), 64'd0);
    check("rst_fmt", 64'(out_fmt), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    exp_cnt = '0;
    rst     = 1'b0;
  endtask

  // Monitor: pop and compare on each output handshake; stalled outputs must hold.
  initial begin : monitor
    exp_t             e;
    logic             hold_v;
    logic [XLEN-1:0]  h_imm;
    logic [2:0]       h_fmt;
    logic [TAG_W-1:0] h_tag;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_imm", 64'(out_imm), 64'(h_imm));
          check("hold_fmt", 64'(out_fmt), 64'(h_fmt));
          check("hold_tag", 64'(out_tag), 64'(h_tag));
        end
        hold_v = out_valid && !out_ready;
        h_imm  = out_imm;
        h_fmt  = out_fmt;
        h_tag  = out_tag;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual tag=%0h required no output", out_tag);
          end else begin
            e = sb.pop_front();
            check("out_imm", 64'(out_imm), 64'(e.imm));
            check("out_fmt", 64'(out_fmt), 64'(e.fmt));
            check("out_tag", 64'(out_tag), 64'(e.tag));
            pops++;
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [6:0]  ops [10];
    logic [31:0] ins;
    logic [31:0] tag_before;
    int          pops_before;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h00};
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    do_reset();

    // Directed formats with literal expectations
    send_lit(32'hFFF00093, 32'hFFFFFFFF, 3'd1);
    idle(1'b1);
    check("latency_valid", 64'(out_valid), 64'd1);
    send_lit(32'h0020A423, 32'h00000008, 3'd2);
    send_lit(32'hFE000EE3, 32'hFFFFFFFC, 3'd3);
    send_lit(32'h123452B7, 32'h12345000, 3'd4);
    send_lit(32'h001000EF, 32'h00000800, 3'd5);
`ifdef GEN_IMM_SHAMT_EN
    send_lit(32'h4030D093, 32'h00000003, 3'd1);
`else
    send_lit(32'h4030D093, 32'h00000403, 3'd1);
`endif
    send_lit(32'h00000000, 32'h00000000, 3'd7);
    idle(1'b1);
    idle(1'b1);
    check("cnt_after_one_ill", 64'(cnt_ilegal), 64'd1);

    // Backpressure: two accepted, third refused, then all three drain in order
    pops_before = pops;
    send(32'h00100093, 1'b0);
    send(32'h00200113, 1'b0);
    send(32'h00300193, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    tag_before = tag_ctr;
    for (int i = 0; i < 10 && tag_ctr == tag_before; i++) send(32'h00300193, 1'b1);
    for (int i = 0; i < 6; i++) idle(1'b1);
    check("bp_drained", 64'(pops - pops_before), 64'd3);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Counter saturation (CNT_W=2): four more illegals stick at 3
    for (int i = 0; i < 4; i++) send(32'h0000007F, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("cnt_saturated", 64'(cnt_ilegal), 64'd3);

    // Reset with the buffer full
    send(32'h00500293, 1'b0);
    send(32'h00600313, 1'b0);
    idle(1'b0);
    check("full_before_rst", 64'(in_ready), 64'd0);
    do_reset();

    // Random traffic with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      ins      = $urandom;
      ins[6:0] = (i % 10 == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      if (i == 1500) do_reset();
      drive_cycle($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0, 1'b0, '0, 3'd0);
    end

    // Bounded drain
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b1);
    idle(1'b1);
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    check("final_out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
